// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter.
// Two write-back requesters (ALU, memory) compete for one register file write port.
// Arbitration is round-robin on ties, and a busy scoreboard tracks outstanding writes.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32,
    localparam int unsigned AW        = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [AW-1:0]         alu_addr,
    input  logic [DATA_WIDTH-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [AW-1:0]         mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    input  logic                  reserve_valid,
    input  logic [AW-1:0]         reserve_addr,
    output logic                  write,
    output logic [AW-1:0]         reg_write_address,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [NUM_REGS-1:0]   busy
);

    // 0: ALU granted most recently, 1: memory granted most recently
    logic                  last_grant;
    logic                  xfer;
    logic                  wr_en;
    logic [AW-1:0]         sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   busy_next;

    // Grant: a lone requester wins; on a tie the requester not granted last wins
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!reset) begin
            if (alu_valid && (!mem_valid || last_grant)) begin
                alu_ready = 1'b1;
            end else if (mem_valid) begin
                mem_ready = 1'b1;
            end
        end
    end

    // Select the granted payload; writes to register 0 are accepted but dropped
    always_comb begin
        xfer     = alu_ready | mem_ready;
        sel_addr = mem_ready ? mem_addr : alu_addr;
        sel_data = mem_ready ? mem_data : alu_data;
        wr_en    = xfer && (sel_addr != '0);
    end

    // Scoreboard update: clear on write, then set on reservation so the newer producer wins
    always_comb begin
        busy_next = busy;
        if (wr_en) begin
            busy_next[sel_addr] = 1'b0;
        end
        if (reserve_valid && (reserve_addr != '0)) begin
            busy_next[reserve_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Write-port register, round-robin pointer and scoreboard state
    always_ff @(posedge clk) begin
        if (reset) begin
            write             <= 1'b0;
            reg_write_address <= '0;
            write_data        <= '0;
            busy              <= '0;
            last_grant        <= 1'b1;
        end else begin
            write <= wr_en;
            if (wr_en) begin
                reg_write_address <= sel_addr;
                write_data        <= sel_data;
            end
            if (xfer) begin
                last_grant <= mem_ready;
            end
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
// Inputs change on the falling edge; ready is sampled before the rising edge,
// registered outputs 1 time unit after it.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, reserve_valid;
    logic [4:0]  alu_addr, mem_addr, reserve_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        write;
    logic [4:0]  reg_write_address;
    logic [31:0] write_data;
    logic [31:0] busy;

    int vectors = 0;
    int miscompares = 0;

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .reserve_valid(reserve_valid), .reserve_addr(reserve_addr),
        .write(write), .reg_write_address(reg_write_address), .write_data(write_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Move to the falling edge and drop all requests
    task automatic idle();
        @(negedge clk);
        alu_valid = 1'b0; mem_valid = 1'b0; reserve_valid = 1'b0;
        alu_addr = '0; mem_addr = '0; reserve_addr = '0;
        alu_data = '0; mem_data = '0;
    endtask

    // Clock the pending inputs in and settle after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1; alu_addr = 5'd7; mem_addr = 5'd8;
        reserve_valid = 1'b1; reserve_addr = 5'd3;
        #1;
        vectors++;
        if ({alu_ready, mem_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 00", {alu_ready, mem_ready});
        end
        step();
        vectors++;
        if ({write, reg_write_address, write_data, busy} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got w=%b a=%0d d=%h busy=%h want 0/0/0/0",
                     write, reg_write_address, write_data, busy);
        end
        idle();
        reset = 1'b0;
        step();
    endtask

    task automatic test_tie();
        idle();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hAAAA0001;
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'hBBBB0002;
        #1;
        vectors++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL tie_first_grant: got %b want 10", {alu_ready, mem_ready});
        end
        step();
        vectors++;
        if ({write, reg_write_address, write_data} !== {1'b1, 5'd5, 32'hAAAA0001}) begin
            miscompares++;
            $display("FAIL tie_alu_write: got w=%b a=%0d d=%h want 1/5/aaaa0001",
                     write, reg_write_address, write_data);
        end
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        vectors++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL tie_second_grant: got %b want 01", {alu_ready, mem_ready});
        end
        step();
        vectors++;
        if ({write, reg_write_address, write_data} !== {1'b1, 5'd6, 32'hBBBB0002}) begin
            miscompares++;
            $display("FAIL tie_mem_write: got w=%b a=%0d d=%h want 1/6/bbbb0002",
                     write, reg_write_address, write_data);
        end
        idle();
        step();
        vectors++;
        if ({write, reg_write_address, write_data} !== {1'b0, 5'd6, 32'hBBBB0002}) begin
            miscompares++;
            $display("FAIL idle_hold: got w=%b a=%0d d=%h want 0/6/bbbb0002",
                     write, reg_write_address, write_data);
        end
    endtask

    // Mem was granted last, so the alternation starts with alu
    task automatic test_contention();
        for (int i = 0; i < 6; i++) begin
            logic        exp_alu;
            logic [4:0]  exp_addr;
            logic [31:0] exp_data;
            exp_alu  = (i % 2) == 0;
            exp_addr = exp_alu ? 5'(10 + i) : 5'(20 + i);
            exp_data = exp_alu ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i);
            @(negedge clk);
            alu_valid = 1'b1; alu_addr = 5'(10 + i); alu_data = 32'hA000_0000 + 32'(i);
            mem_valid = 1'b1; mem_addr = 5'(20 + i); mem_data = 32'hB000_0000 + 32'(i);
            #1;
            vectors++;
            if ({alu_ready, mem_ready} !== {exp_alu, ~exp_alu}) begin
                miscompares++;
                $display("FAIL contention_grant[%0d]: got %b want %b", i,
                         {alu_ready, mem_ready}, {exp_alu, ~exp_alu});
            end
            step();
            vectors++;
            if ({write, reg_write_address, write_data} !== {1'b1, exp_addr, exp_data}) begin
                miscompares++;
                $display("FAIL contention_write[%0d]: got w=%b a=%0d d=%h want 1/%0d/%h", i,
                         write, reg_write_address, write_data, exp_addr, exp_data);
            end
        end
    endtask

    task automatic test_addr_zero();
        idle();
        reserve_valid = 1'b1; reserve_addr = 5'd4;
        step();
        idle();
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hDEADBEEF;
        #1;
        vectors++;
        if ({alu_ready, mem_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL addr0_ready: got %b want 01", {alu_ready, mem_ready});
        end
        step();
        vectors++;
        if ({write, reg_write_address, write_data, busy} !==
            {1'b0, 5'd25, 32'hB000_0005, 32'h0000_0010}) begin
            miscompares++;
            $display("FAIL addr0_discard: got w=%b a=%0d d=%h busy=%h want 0/25/b0000005/00000010",
                     write, reg_write_address, write_data, busy);
        end
        // The discarded mem transfer still counts as the last grant
        idle();
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h0000_4444;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h0000_7777;
        #1;
        vectors++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL addr0_last_grant: got %b want 10", {alu_ready, mem_ready});
        end
        step();
        vectors++;
        if ({write, reg_write_address, busy} !== {1'b1, 5'd4, 32'd0}) begin
            miscompares++;
            $display("FAIL addr0_followup: got w=%b a=%0d busy=%h want 1/4/00000000",
                     write, reg_write_address, busy);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        reserve_valid = 1'b1; reserve_addr = 5'd9;
        step();
        vectors++;
        if (busy !== 32'h0000_0200) begin
            miscompares++;
            $display("FAIL sb_set: got %h want 00000200", busy);
        end
        idle();
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h9999_0001;
        step();
        vectors++;
        if ({write, busy} !== {1'b1, 32'd0}) begin
            miscompares++;
            $display("FAIL sb_clear: got w=%b busy=%h want 1/00000000", write, busy);
        end
        idle();
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h9999_0002;
        reserve_valid = 1'b1; reserve_addr = 5'd9;
        step();
        vectors++;
        if ({write, busy} !== {1'b1, 32'h0000_0200}) begin
            miscompares++;
            $display("FAIL sb_same_addr: got w=%b busy=%h want 1/00000200", write, busy);
        end
        idle();
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h9999_0003;
        reserve_valid = 1'b1; reserve_addr = 5'd12;
        step();
        vectors++;
        if (busy !== 32'h0000_1000) begin
            miscompares++;
            $display("FAIL sb_diff_addr: got %h want 00001000", busy);
        end
        idle();
        reserve_valid = 1'b1; reserve_addr = 5'd0;
        step();
        vectors++;
        if (busy !== 32'h0000_1000) begin
            miscompares++;
            $display("FAIL sb_reserve_r0: got %h want 00001000", busy);
        end
        idle();
        alu_valid = 1'b1; alu_addr = 5'd15; alu_data = 32'h1515_1515;
        step();
        vectors++;
        if ({write, reg_write_address, busy} !== {1'b1, 5'd15, 32'h0000_1000}) begin
            miscompares++;
            $display("FAIL sb_clear_idle: got w=%b a=%0d busy=%h want 1/15/00001000",
                     write, reg_write_address, busy);
        end
    endtask

    // Alu was granted last before reset; reset must hand the next tie back to alu
    task automatic test_reset_mid();
        idle();
        reset = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h3333_3333;
        reserve_valid = 1'b1; reserve_addr = 5'd7;
        step();
        vectors++;
        if ({write, reg_write_address, write_data, busy} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_mid: got w=%b a=%0d d=%h busy=%h want 0/0/0/0",
                     write, reg_write_address, write_data, busy);
        end
        idle();
        reset = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1111_0000;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h2222_0000;
        #1;
        vectors++;
        if ({alu_ready, mem_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_mid_tie: got %b want 10", {alu_ready, mem_ready});
        end
        step();
        vectors++;
        if ({write, reg_write_address, write_data} !== {1'b1, 5'd1, 32'h1111_0000}) begin
            miscompares++;
            $display("FAIL reset_mid_resume: got w=%b a=%0d d=%h want 1/1/11110000",
                     write, reg_write_address, write_data);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 1; i <= 3; i++) begin
            if (i > 1) @(negedge clk);
            mem_valid = 1'b1; mem_addr = 5'(i); mem_data = 32'h0000_1000 + 32'(i);
            #1;
            vectors++;
            if ({alu_ready, mem_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: got %b want 01", i, {alu_ready, mem_ready});
            end
            step();
            vectors++;
            if ({write, reg_write_address, write_data} !== {1'b1, 5'(i), 32'h0000_1000 + 32'(i)}) begin
                miscompares++;
                $display("FAIL b2b_write[%0d]: got w=%b a=%0d d=%h want 1/%0d/%h", i,
                         write, reg_write_address, write_data, i, 32'h0000_1000 + 32'(i));
            end
        end
        idle();
        step();
    endtask

    initial begin
        reset = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0; reserve_valid = 1'b0;
        alu_addr = '0; mem_addr = '0; reserve_addr = '0;
        alu_data = '0; mem_data = '0;
        test_reset();
        test_tie();
        test_contention();
        test_addr_zero();
        test_scoreboard();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
